decode_module: RTL and testbench

//  Decode + write-back stage of the Y86-64 SEQ processor.

---
 rtl/y86_pkg.sv | 24 ++
 rtl/decode_module_if.sv | 18 +
 rtl/y86_regfile.sv | 51 +++++
 rtl/decode_module.sv | 58 +++++
 tb/tb_decode_module.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and sizes for the SEQ decode/write-back stage.
// Optional feature macro used by y86_regfile: REGFILE_BYPASS_EN.
package y86_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/decode_module_if.sv
// Fetch/execute-facing bus of the decode stage. There is no handshake: inputs are
// sampled every cycle, valA/valB are combinational and valid whenever inputs are.
interface decode_module_if;
  import y86_pkg::*;

  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;

  modport master (output icode, rA, rB, cnd, valE, valM, input valA, valB);
  modport slave  (input icode, rA, rB, cnd, valE, valM, output valA, valB);

endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational reads, two write ports with M over E.
// Build option REGFILE_BYPASS_EN forwards same-cycle write data to the read ports.
module y86_regfile
  import y86_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  input  logic [3:0]        dst_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] wdata_e,
  input  logic [DATA_W-1:0] wdata_m,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // Per-entry compare keeps ID 0xF out of the array and gives port M priority.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n)
        regs[i] <= DATA_W'(i);
      else if (dst_m == 4'(i))
        regs[i] <= wdata_m;
      else if (dst_e == 4'(i))
        regs[i] <= wdata_e;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] src);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++)
      if (src == 4'(i)) r = regs[i];
`ifdef REGFILE_BYPASS_EN
    if (rst_n && src != RNONE) begin
      if (src == dst_m)      r = wdata_m;
      else if (src == dst_e) r = wdata_e;
    end
`endif
    return r;
  endfunction

  always_comb begin
    rdata_a = read_port(src_a);
    rdata_b = read_port(src_b);
  end

endmodule

// File: rtl/decode_module.sv
// Y86-64 SEQ decode + write-back: register selection from icode/rA/rB/cnd and the
// register file instance. REGFILE_BYPASS_EN (in y86_regfile) enables write forwarding.
module decode_module
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  decode_module_if.slave  bus
);

  logic [3:0] src_a, src_b, dst_e, dst_m;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;

    case (bus.icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = bus.rA;
      IRET, IPOPQ:                    src_a = RRSP;
      default:                        ;
    endcase

    case (bus.icode)
      IRMMOVQ, IMRMOVQ, IOPQ:      src_b = bus.rB;
      ICALL, IRET, IPUSHQ, IPOPQ:  src_b = RRSP;
      default:                     ;
    endcase

    // cmovXX only commits when execute reports the condition true.
    case (bus.icode)
      IIRMOVQ, IOPQ:               dst_e = bus.rB;
      IRRMOVQ:                     dst_e = bus.cnd ? bus.rB : RNONE;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RRSP;
      default:                     ;
    endcase

    case (bus.icode)
      IMRMOVQ, IPOPQ: dst_m = bus.rA;
      default:        ;
    endcase
  end

  y86_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .src_a   (src_a),
    .src_b   (src_b),
    .dst_e   (dst_e),
    .dst_m   (dst_m),
    .wdata_e (bus.valE),
    .wdata_m (bus.valM),
    .rdata_a (bus.valA),
    .rdata_b (bus.valB)
  );

endmodule

// File: tb/tb_decode_module.sv
// Bench for decode_module: set-membership register model, per-cycle compare of
// valA/valB on the falling edge, pinned literal cases, randomized traffic.
module tb_decode_module;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  bit   chk_en;

  decode_module_if bus_if ();

  decode_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: 16 slots, slot 15 is never written and reads as zero
  logic [63:0] model_r [16];

  function automatic bit in_set(input logic [15:0] set, input logic [3:0] ic);
    return set[ic];
  endfunction

  function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
    if (in_set(16'h0454, ic)) return ra;       // 2,4,6,A
    if (in_set(16'h0A00, ic)) return 4'h4;     // 9,B
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
    if (in_set(16'h0070, ic)) return rb;       // 4,5,6
    if (in_set(16'h0F00, ic)) return 4'h4;     // 8..B
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (in_set(16'h0048, ic)) return rb;       // 3,6
    if (ic == 4'h2 && c)      return rb;
    if (in_set(16'h0F00, ic)) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    if (in_set(16'h0820, ic)) return ra;       // 5,B
    return 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s);
    logic [3:0] de, dm;
    de = m_dst_e(bus_if.icode, bus_if.rB, bus_if.cnd);
    dm = m_dst_m(bus_if.icode, bus_if.rA);
    if (s == 4'hF) return 64'd0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && s == dm) return bus_if.valM;
    if (rst_n && s == de) return bus_if.valE;
`else
    if (de == dm && de == 4'hE) return model_r[s];  // no forwarding in this build
`endif
    return model_r[s];
  endfunction

  always @(posedge clk) begin
    logic [3:0] de, dm;
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) model_r[i] = 64'(i);
    end else begin
      de = m_dst_e(bus_if.icode, bus_if.rB, bus_if.cnd);
      dm = m_dst_m(bus_if.icode, bus_if.rA);
      if (de != 4'hF) model_r[de] = bus_if.valE;
      if (dm != 4'hF) model_r[dm] = bus_if.valM;
    end
  end

  // scoreboard check
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (icode=%0h rA=%0h rB=%0h t=%0t)",
                  name, act, exp, bus_if.icode, bus_if.rA, bus_if.rB, $time);
  endtask

  // compare process: every falling edge once the register file has been reset
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valA", bus_if.valA, m_read(m_src_a(bus_if.icode, bus_if.rA)));
      check("model_valB", bus_if.valB, m_read(m_src_b(bus_if.icode, bus_if.rB)));
    end
  end

  // driver tasks
  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic c, input logic [63:0] ve, input logic [63:0] vm);
    bus_if.icode = ic;
    bus_if.rA    = ra;
    bus_if.rB    = rb;
    bus_if.cnd   = c;
    bus_if.valE  = ve;
    bus_if.valM  = vm;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [3:0] ic, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [63:0] ea, input logic [63:0] eb);
    drive(ic, ra, rb, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    check({name, "_valA"}, bus_if.valA, ea);
    check({name, "_valB"}, bus_if.valB, eb);
    next_cycle();
  endtask

  initial begin
    checks = 0;
    passed = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
    next_cycle();
    chk_en = 1'b1;

    // reset contents visible while rst_n stays low
    pin("rst_cmov",  4'h2, 4'h1, 4'h8, 64'd1,  64'd0);
    pin("rst_rmmov", 4'h4, 4'h3, 4'h3, 64'd3,  64'd3);
    pin("rst_mrmov", 4'h5, 4'h4, 4'h4, 64'd0,  64'd4);
    pin("rst_call",  4'h8, 4'h8, 4'h8, 64'd0,  64'd4);
    pin("rst_push",  4'hA, 4'hA, 4'h0, 64'd10, 64'd4);
    pin("rst_pop",   4'hB, 4'hB, 4'h1, 64'd4,  64'd4);

    // popq %rsp: port M wins
    rst_n = 1'b1;
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h20, 64'h99);
    next_cycle();
    drive(4'hA, 4'h4, 4'hF, 1'b0, 64'h99, 64'h0);
    @(negedge clk);
    check("popq_rsp_valA", bus_if.valA, 64'h99);
    next_cycle();

    // cmov with cnd=0 must not write
    drive(4'h2, 4'h0, 4'h3, 1'b0, 64'h7, 64'h0);
    next_cycle();
    drive(4'h6, 4'h3, 4'h5, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    check("cmov_nc_R3", bus_if.valA, 64'd3);
    next_cycle();

    // cmov with cnd=1 writes rB
    drive(4'h2, 4'h0, 4'h3, 1'b1, 64'h1234, 64'h0);
    next_cycle();
    drive(4'h6, 4'h3, 4'h5, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    check("cmov_c_R3", bus_if.valA, 64'h1234);
    next_cycle();

    // randomized traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom});
      next_cycle();
    end

    rst_n = 1'b1;
    drive(4'h1, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
